video_router_sync_pio: RTL and testbench
========================================

Name: video_router_sync_pio

Overview:
- Parametrised Avalon-MM output-port controller. Successor to the single-bit router-select PIO used in the edge-detection subsystem.
- Drives a WIDTH-bit control word, for example video router select and mode bits.
- A CPU write is staged as a pending value. It reaches out_port only on a frame-boundary strobe (sof), or on a timeout, or at once in immediate mode. This stops the router switching mid-frame.
- Also provides cancel, status and an apply counter.

Parameters:
WIDTH, 1, width of out_port and of the data/pending registers (1..32)
RESET_VALUE, 0, out_port and pending value after reset
TIMEOUT_CYCLES, 0, cycles in PENDING before a forced apply; 0 disables the timeout
IMMEDIATE_DEFAULT, 0, reset value of CONTROL.immediate

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
address  in  3  Avalon-MM word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
sof  in  1  one-cycle start-of-frame strobe from the video stream
out_port  out  WIDTH  applied control word
readdata  out  32  read data; combinational from address, zero wait states
irq  out  1  high while STATUS.applied_flag=1 and CONTROL.irq_en=1

Behaviour:
- Reset (reset_n low at a clk edge) sets:
  - out_port and pending to RESET_VALUE
  - state to IDLE; timeout counter to 0
  - applied_flag and forced to 0; apply_count to 0
  - immediate to IMMEDIATE_DEFAULT; irq_en to 0
- A write is any cycle with chipselect=1 and write_n=0.
- Address map (unused bits read 0; addresses 5-7 read 0 and ignore writes):
  - 0 DATA. Read returns out_port, zero-extended. A write loads pending with writedata[WIDTH-1:0].
  - 1 PENDING. Read returns pending. Writes are ignored.
  - 2 STATUS. Read: bit0 = (state==PENDING), bit1 = forced, bit2 = applied_flag. Write: bit0=1 cancels any pending update; bit2=1 clears applied_flag.
  - 3 CONTROL. Read/write: bit0 immediate, bit1 irq_en.
  - 4 APPLY_COUNT. Read returns a 16-bit count, zero-extended. Any write clears it to 0.
- State machine. IDLE:
  - A DATA write with immediate=1 gives out_port = writedata on the next edge. This is an apply with forced=0. State stays IDLE.
  - A DATA write with immediate=0 goes to PENDING and sets the timeout counter to 0.
- State machine. PENDING, evaluated in this priority order:
  - A cancel write goes to IDLE. out_port is unchanged and no apply happens. Cancel beats a same-cycle sof or timeout.
  - sof=1 applies pending to out_port on that edge, with forced=0, and goes to IDLE.
  - Otherwise, if TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1, apply with forced=1 and go to IDLE.
  - Otherwise the counter increments.
- A DATA write while in PENDING overwrites pending and restarts the counter at 0.
- A DATA write in the same cycle as an apply (sof or timeout):
  - The old pending value is applied.
  - The new value becomes pending and the state stays PENDING, with the counter at 0.
  - With immediate=1, the new write value is applied instead.
- Every apply:
  - sets applied_flag
  - increments apply_count, saturating at 16'hFFFF
  - updates forced
- Writing the same value as out_port still counts as an apply.
- sof while in IDLE has no effect.
- Setting immediate to 1 while PENDING does not flush the pending value. It waits for sof or the timeout.
- APPLY_COUNT clear in the same cycle as an apply: the clear wins, so the result is 0.
- Reset asserted mid-PENDING discards the pending value. out_port returns to RESET_VALUE on that edge.
- Latency is one clk from the qualifying edge (write, sof or timeout) to out_port changing. readdata reflects register state in the same cycle.

Test Plan:
- WIDTH=2, RESET_VALUE=1: hold reset_n low for 2 clks, then read all 8 addresses -> out_port=1; reads give 1,1,0,0,0,0,0,0.
- immediate=0: write DATA=2, wait 5 clks, then pulse sof -> STATUS=1 before sof; out_port=2 one clk after sof; STATUS=4; APPLY_COUNT=1.
- TIMEOUT_CYCLES=10: write DATA=3 with no sof -> out_port=3 exactly 10 clks after the write edge; STATUS=6; irq=1 only if irq_en=1; write STATUS=4 -> irq=0.
- Write DATA=2 in PENDING, then write DATA=3 in the same cycle as sof -> out_port=2; PENDING reads 3; STATUS bit0=1; the next sof gives out_port=3.
- Cancel write in the same cycle as sof -> out_port unchanged, STATUS=0, APPLY_COUNT unchanged. Separately, immediate=1 with write DATA=0 -> out_port=0 one clk later.
- Drive reset_n low mid-PENDING -> out_port=RESET_VALUE; a later sof causes no apply; APPLY_COUNT=0.

Source files
------------

// File: rtl/video_router_sync_pio_if.sv
// Avalon-MM slave bus bundle for the frame-synchronised router-select PIO.
interface video_router_sync_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );
endinterface

// File: rtl/video_router_sync_pio.sv
// Frame-synchronised output-port controller: CPU writes are staged as pending and
// reach out_port on sof, on a timeout, or at once in immediate mode.
module video_router_sync_pio #(
  parameter int unsigned WIDTH             = 1,
  parameter logic [31:0] RESET_VALUE       = 32'd0,
  parameter int unsigned TIMEOUT_CYCLES    = 0,
  parameter bit          IMMEDIATE_DEFAULT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  video_router_sync_pio_if.slave  avs,
  input  logic                    sof,
  output logic [WIDTH-1:0]        out_port,
  output logic                    irq
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pending;
  logic             applied_flag;
  logic             forced;
  logic [15:0]      apply_count;
  logic             immediate;
  logic             irq_en;
  logic [31:0]      tmo_cnt;

  logic             wr, data_wr, status_wr, ctrl_wr, cnt_wr, cancel_wr;
  logic             tmo_hit;
  logic             apply;
  logic             apply_forced;
  logic [WIDTH-1:0] apply_val;
  logic             unused_wdata;

  assign wr        = avs.chipselect && !avs.write_n;
  assign data_wr   = wr && (avs.address == 3'd0);
  assign status_wr = wr && (avs.address == 3'd2);
  assign ctrl_wr   = wr && (avs.address == 3'd3);
  assign cnt_wr    = wr && (avs.address == 3'd4);
  assign cancel_wr = status_wr && avs.writedata[0];
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (state == PENDING) &&
                     (tmo_cnt == TIMEOUT_CYCLES - 1);
  assign unused_wdata = &{1'b0, avs.writedata};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (data_wr && !immediate) state_nx = PENDING;
      end
      PENDING: begin
        // A new DATA write keeps us pending even when the old value applies this edge
        if (data_wr)                          state_nx = immediate ? IDLE : PENDING;
        else if (cancel_wr || sof || tmo_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    apply        = 1'b0;
    apply_forced = 1'b0;
    apply_val    = pending;
    if (data_wr && immediate) begin
      apply     = 1'b1;
      apply_val = avs.writedata[WIDTH-1:0];
    end else if (state == PENDING && !cancel_wr) begin
      if (sof) begin
        apply = 1'b1;
      end else if (tmo_hit) begin
        apply        = 1'b1;
        apply_forced = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_port     <= RESET_VALUE[WIDTH-1:0];
      pending      <= RESET_VALUE[WIDTH-1:0];
      applied_flag <= 1'b0;
      forced       <= 1'b0;
      apply_count  <= '0;
      immediate    <= IMMEDIATE_DEFAULT;
      irq_en       <= 1'b0;
      tmo_cnt      <= '0;
    end else begin
      if (apply) begin
        out_port <= apply_val;
        forced   <= apply_forced;
      end
      if (data_wr) pending <= avs.writedata[WIDTH-1:0];

      if (data_wr)               tmo_cnt <= '0;
      else if (state == PENDING) tmo_cnt <= tmo_cnt + 32'd1;

      // A same-cycle apply re-raises the flag over a clear request
      if (apply)                                applied_flag <= 1'b1;
      else if (status_wr && avs.writedata[2])   applied_flag <= 1'b0;

      if (cnt_wr)                               apply_count <= '0;
      else if (apply && apply_count != 16'hFFFF) apply_count <= apply_count + 16'd1;

      if (ctrl_wr) begin
        immediate <= avs.writedata[0];
        irq_en    <= avs.writedata[1];
      end
    end
  end

  always_comb begin
    avs.readdata = '0;
    unique case (avs.address)
      3'd0: avs.readdata[WIDTH-1:0] = out_port;
      3'd1: avs.readdata[WIDTH-1:0] = pending;
      3'd2: avs.readdata[2:0]       = {applied_flag, forced, state == PENDING};
      3'd3: avs.readdata[1:0]       = {irq_en, immediate};
      3'd4: avs.readdata[15:0]      = apply_count;
      default: avs.readdata = '0;
    endcase
  end

  assign irq = applied_flag && irq_en;

endmodule

// File: tb/tb_video_router_sync_pio.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_video_router_sync_pio;

  localparam int unsigned WIDTH = 2;
  localparam logic [31:0] RV    = 32'd1;
  localparam int unsigned TO    = 10;
  localparam logic [31:0] MASK  = 32'h3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sof;
  logic [WIDTH-1:0] out_port;
  logic             irq;

  video_router_sync_pio_if bus ();

  video_router_sync_pio #(
    .WIDTH(WIDTH),
    .RESET_VALUE(RV),
    .TIMEOUT_CYCLES(TO),
    .IMMEDIATE_DEFAULT(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs(bus),
    .sof(sof),
    .out_port(out_port),
    .irq(irq)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: a pending update is a value plus its age; each edge decides
  // whether something is applied, what value and whether it was forced.
  logic [31:0] m_out, m_pend, m_age, m_val;
  logic [15:0] m_count;
  logic        m_busy, m_flag, m_forced, m_imm, m_irqen;
  logic        m_wr, m_apply, m_frc, m_nbusy;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_out = RV; m_pend = RV; m_busy = 0; m_age = 0; m_flag = 0; m_forced = 0;
      m_count = 0; m_imm = 0; m_irqen = 0;
    end else begin
      m_wr = bus.chipselect && !bus.write_n;
      m_apply = 0; m_val = 0; m_frc = 0; m_nbusy = m_busy;
      if (m_busy) begin
        if (m_wr && bus.address == 2 && bus.writedata[0]) m_nbusy = 0;
        else if (sof) begin m_apply = 1; m_val = m_pend; m_nbusy = 0; end
        else if (m_age == TO - 1) begin m_apply = 1; m_val = m_pend; m_frc = 1; m_nbusy = 0; end
      end
      if (m_wr && bus.address == 0) begin
        if (m_imm) begin m_apply = 1; m_val = bus.writedata & MASK; m_frc = 0; m_nbusy = 0; end
        else m_nbusy = 1;
      end
      m_age = (m_wr && bus.address == 0) ? 0 : m_age + 1;
      if (m_wr && bus.address == 0) m_pend = bus.writedata & MASK;
      if (m_apply) begin m_out = m_val; m_forced = m_frc; end
      if (m_apply) m_flag = 1;
      else if (m_wr && bus.address == 2 && bus.writedata[2]) m_flag = 0;
      if (m_wr && bus.address == 4) m_count = 0;
      else if (m_apply && m_count != 16'hFFFF) m_count = m_count + 1;
      if (m_wr && bus.address == 3) begin m_imm = bus.writedata[0]; m_irqen = bus.writedata[1]; end
      m_busy = m_nbusy;
    end
  end

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_out;
      3'd1:    return m_pend;
      3'd2:    return {29'b0, m_flag, m_forced, m_busy};
      3'd3:    return {30'b0, m_irqen, m_imm};
      3'd4:    return {16'b0, m_count};
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.chipselect = 0; bus.write_n = 1; sof = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic s);
    bus.address = a; bus.writedata = d; bus.chipselect = 1; bus.write_n = 0; sof = s;
    tick();
    idle_bus();
  endtask

  task automatic pulse_sof();
    sof = 1; tick(); sof = 0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check_eq(tag, bus.readdata, exp);
  endtask

  task automatic check_model_all(input string tag);
    check_eq({tag, "_out"}, 32'(out_port), m_out);
    check_eq({tag, "_irq"}, 32'(irq), 32'(m_flag & m_irqen));
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      #1;
      check_eq($sformatf("%s_rd%0d", tag, a), bus.readdata, model_read(3'(a)));
    end
  endtask

  logic [31:0] reset_reads [8];
  int          n;
  logic [2:0]  ra;

  initial begin
    reset_reads = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    reset_n = 0; sof = 0;
    bus.address = 0; bus.writedata = 0; bus.chipselect = 0; bus.write_n = 1;

    // Reset state
    tick(); tick();
    reset_n = 1;
    check_eq("rst_out", 32'(out_port), 32'd1);
    for (int a = 0; a < 8; a++) rd_check($sformatf("rst_rd%0d", a), 3'(a), reset_reads[a]);

    // Staged write applied on sof
    wr(3'd0, 32'd2, 0);
    for (int i = 0; i < 5; i++) tick();
    rd_check("stage_status", 3'd2, 32'd1);
    check_eq("stage_out_held", 32'(out_port), 32'd1);
    pulse_sof();
    check_eq("sof_out", 32'(out_port), 32'd2);
    rd_check("sof_status", 3'd2, 32'd4);
    rd_check("sof_count", 3'd4, 32'd1);
    check_model_all("t2");

    // Timeout forced apply and irq
    wr(3'd2, 32'd4, 0);
    wr(3'd3, 32'd2, 0);
    wr(3'd0, 32'd3, 0);
    n = 0;
    while (out_port != 2'd3 && n < 20) begin tick(); n++; end
    check_eq("tmo_latency", 32'(n), 32'd10);
    rd_check("tmo_status", 3'd2, 32'd6);
    check_eq("tmo_irq", 32'(irq), 32'd1);
    wr(3'd2, 32'd4, 0);
    check_eq("irq_clear", 32'(irq), 32'd0);
    check_model_all("t3");

    // DATA write coincident with sof
    wr(3'd3, 32'd0, 0);
    wr(3'd0, 32'd2, 0);
    wr(3'd0, 32'd3, 1);
    check_eq("coinc_out", 32'(out_port), 32'd2);
    rd_check("coinc_pend", 3'd1, 32'd3);
    rd_check("coinc_status", 3'd2, 32'd5);
    pulse_sof();
    check_eq("coinc_next", 32'(out_port), 32'd3);
    check_model_all("t4");

    // Cancel beats sof, then immediate mode
    wr(3'd2, 32'd4, 0);
    wr(3'd0, 32'd1, 0);
    wr(3'd2, 32'd1, 1);
    check_eq("cancel_out", 32'(out_port), 32'd3);
    rd_check("cancel_status", 3'd2, 32'd0);
    rd_check("cancel_count", 3'd4, 32'd4);
    wr(3'd3, 32'd1, 0);
    wr(3'd0, 32'd0, 0);
    check_eq("imm_out", 32'(out_port), 32'd0);
    check_model_all("t5");

    // Reset mid-PENDING
    wr(3'd3, 32'd0, 0);
    wr(3'd0, 32'd2, 0);
    reset_n = 0; tick(); reset_n = 1;
    check_eq("midrst_out", 32'(out_port), 32'd1);
    pulse_sof();
    check_eq("midrst_sof_out", 32'(out_port), 32'd1);
    rd_check("midrst_count", 3'd4, 32'd0);
    rd_check("midrst_status", 3'd2, 32'd0);
    check_model_all("t6");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      bus.chipselect = 1'($urandom_range(0, 1));
      bus.write_n = 1'($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ra = 3'd0;
      bus.address = ra;
      bus.writedata = $urandom;
      sof = ($urandom_range(0, 5) == 0);
      #1;
      check_eq("rnd_read", bus.readdata, model_read(ra));
      check_eq("rnd_out", 32'(out_port), m_out);
      check_eq("rnd_irq", 32'(irq), 32'(m_flag & m_irqen));
      tick();
    end
    reset_n = 1;
    idle_bus();
    tick();
    check_model_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
